// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - single-barrier parking gate arbiter with password entry
//
// Purpose: arbitrates one shared barrier between an entrance lane (password
// protected) and an exit lane, tracks lot occupancy and drives the lane LEDs.
// Every output comes straight from a flop; the next-cycle values are decoded
// from the next state so outputs change on the same edge as the state.
//
// Ports:
//   i_clk            clock, all state updates on its rising edge
//   i_reset          synchronous, active-high reset
//   i_entry_req      level, car at entrance sensor
//   i_exit_req       level, car at exit sensor
//   i_password       2-bit entry code, qualified by i_password_valid
//   i_password_valid one-cycle strobe for i_password
//   o_gate_open      barrier raised
//   o_entry_grant    one-cycle pulse, entrance lane granted
//   o_exit_grant     one-cycle pulse, exit lane granted
//   o_green_led      car may pass
//   o_red_led        stop / waiting / denied / lot full
//   o_occupancy      cars currently parked
//   o_full           occupancy == CAPACITY
//   o_empty          occupancy == 0
module parking_gate_arbiter #(
  parameter int unsigned CAPACITY    = 4,
  parameter logic [1:0]  PASSWORD    = 2'b11,
  parameter int unsigned OPEN_CYCLES = 8,
  parameter int unsigned PW_TIMEOUT  = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_entry_req,
  input  logic       i_exit_req,
  input  logic [1:0] i_password,
  input  logic       i_password_valid,
  output logic       o_gate_open,
  output logic       o_entry_grant,
  output logic       o_exit_grant,
  output logic       o_green_led,
  output logic       o_red_led,
  output logic [3:0] o_occupancy,
  output logic       o_full,
  output logic       o_empty
);

  typedef enum logic [2:0] {IDLE, PW_WAIT, OPEN_IN, OPEN_OUT, DENY} state_t;

  localparam logic [3:0] LP_CAP       = 4'(CAPACITY);
  // Timers count 0..N-1 inside a state; leaving happens on the edge that sees N-1.
  localparam logic [7:0] LP_OPEN_LAST = 8'(OPEN_CYCLES - 1);
  localparam logic [7:0] LP_PW_LAST   = 8'(PW_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_timer;
  logic [3:0] r_occupancy;
  logic       r_last_exit;   // 1: exit lane was served most recently
  logic       r_gate_open;
  logic       r_entry_grant;
  logic       r_exit_grant;
  logic       r_red_led;
  logic       r_full;
  logic       r_empty;

  state_t     w_next_state;
  logic [7:0] w_next_timer;
  logic [3:0] w_next_occ;
  logic       w_next_last_exit;
  logic       w_entry_grant;
  logic       w_exit_grant;
  logic       w_entry_valid;
  logic       w_exit_valid;
  logic       w_next_open;
  logic       w_next_full;
  logic       w_next_red;

  always_comb begin
    w_next_state     = r_state;
    w_next_timer     = r_timer;
    w_next_occ       = r_occupancy;
    w_next_last_exit = r_last_exit;
    w_entry_grant    = 1'b0;
    w_exit_grant     = 1'b0;
    // Gating on full/empty is what keeps occupancy inside 0..CAPACITY.
    w_entry_valid    = i_entry_req && (r_occupancy != LP_CAP);
    w_exit_valid     = i_exit_req && (r_occupancy != 4'd0);

    case (r_state)
      IDLE: begin
        w_next_timer = 8'd0;
        // On a tie the lane that was not served last wins.
        if (w_entry_valid && (!w_exit_valid || r_last_exit)) begin
          w_next_state     = PW_WAIT;
          w_entry_grant    = 1'b1;
          w_next_last_exit = 1'b0;
        end else if (w_exit_valid) begin
          w_next_state     = OPEN_OUT;
          w_exit_grant     = 1'b1;
          w_next_last_exit = 1'b1;
          w_next_occ       = r_occupancy - 4'd1;
        end
      end
      PW_WAIT: begin
        // A strobe on the final timeout edge still counts.
        if (i_password_valid) begin
          w_next_timer = 8'd0;
          if (i_password == PASSWORD) begin
            w_next_state = OPEN_IN;
            w_next_occ   = r_occupancy + 4'd1;
          end else begin
            w_next_state = DENY;
          end
        end else if (r_timer == LP_PW_LAST) begin
          w_next_state = IDLE;
          w_next_timer = 8'd0;
        end else begin
          w_next_timer = r_timer + 8'd1;
        end
      end
      OPEN_IN, OPEN_OUT, DENY: begin
        if (r_timer == LP_OPEN_LAST) begin
          w_next_state = IDLE;
          w_next_timer = 8'd0;
        end else begin
          w_next_timer = r_timer + 8'd1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_timer = 8'd0;
      end
    endcase

    w_next_open = (w_next_state == OPEN_IN) || (w_next_state == OPEN_OUT);
    w_next_full = (w_next_occ == LP_CAP);
    w_next_red  = (w_next_state == PW_WAIT) || (w_next_state == DENY) ||
                  ((w_next_state == IDLE) && w_next_full);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_timer       <= 8'd0;
      r_occupancy   <= 4'd0;
      r_last_exit   <= 1'b1;
      r_gate_open   <= 1'b0;
      r_entry_grant <= 1'b0;
      r_exit_grant  <= 1'b0;
      r_red_led     <= 1'b0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
    end else begin
      r_state       <= w_next_state;
      r_timer       <= w_next_timer;
      r_occupancy   <= w_next_occ;
      r_last_exit   <= w_next_last_exit;
      r_gate_open   <= w_next_open;
      r_entry_grant <= w_entry_grant;
      r_exit_grant  <= w_exit_grant;
      r_red_led     <= w_next_red;
      r_full        <= w_next_full;
      r_empty       <= (w_next_occ == 4'd0);
    end
  end

  // Green and gate share one flop, so they can never disagree, and red is
  // never set in the open states.
  assign o_gate_open   = r_gate_open;
  assign o_green_led   = r_gate_open;
  assign o_entry_grant = r_entry_grant;
  assign o_exit_grant  = r_exit_grant;
  assign o_red_led     = r_red_led;
  assign o_occupancy   = r_occupancy;
  assign o_full        = r_full;
  assign o_empty       = r_empty;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - directed table-driven bench for parking_gate_arbiter
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [1:0] password = 2'd0;
  logic       password_valid = 1'b0;
  logic       gate_open, entry_grant, exit_grant, green_led, red_led, full, empty;
  logic [3:0] occupancy;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] m_occ;

  typedef struct packed {
    logic       en;
    logic       ex;
    logic [1:0] pw;
    logic       pv;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  parking_gate_arbiter dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_entry_req      (entry_req),
    .i_exit_req       (exit_req),
    .i_password       (password),
    .i_password_valid (password_valid),
    .o_gate_open      (gate_open),
    .o_entry_grant    (entry_grant),
    .o_exit_grant     (exit_grant),
    .o_green_led      (green_led),
    .o_red_led        (red_led),
    .o_occupancy      (occupancy),
    .o_full           (full),
    .o_empty          (empty)
  );

  // Packs {gate, entry_grant, exit_grant, green, red, occupancy, full, empty}.
  function automatic logic [9:0] ex(input logic g, input logic eg, input logic xg,
                                    input logic gr, input logic rd, input logic [3:0] oc,
                                    input logic f, input logic em);
    return {g, eg, xg, gr, rd, oc, f, em};
  endfunction

  task automatic step(input logic rst, input logic en, input logic xr,
                      input logic [1:0] pw, input logic pv);
    reset          = rst;
    entry_req      = en;
    exit_req       = xr;
    password       = pw;
    password_valid = pv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [9:0] exp);
    logic [9:0] act;
    act = {gate_open, entry_grant, exit_grant, green_led, red_led, occupancy, full, empty};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {gate,eg,xg,grn,red,occ,full,empty}=%b want %b", nm, act, exp);
    end
  endtask

  function automatic logic is_full();
    return m_occ == 4'd4;
  endfunction

  function automatic logic is_empty();
    return m_occ == 4'd0;
  endfunction

  task automatic enter_car(input string nm);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk({nm, "_grant"}, ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, m_occ, is_full(), is_empty()));
    m_occ = m_occ + 4'd1;
    step(1'b0, 1'b0, 1'b0, 2'b11, 1'b1);
    chk({nm, "_open"}, ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, m_occ, is_full(), 1'b0));
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      chk({nm, "_hold"}, ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, m_occ, is_full(), 1'b0));
    end
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk({nm, "_idle"}, ex(1'b0, 1'b0, 1'b0, 1'b0, is_full(), m_occ, is_full(), 1'b0));
  endtask

  task automatic exit_car(input string nm);
    m_occ = m_occ - 4'd1;
    step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    chk({nm, "_grant"}, ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, m_occ, 1'b0, is_empty()));
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      chk({nm, "_hold"}, ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, m_occ, 1'b0, is_empty()));
    end
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk({nm, "_idle"}, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_occ, 1'b0, is_empty()));
  endtask

  initial begin
    // Good entry with password 11, one ignored wrong strobe while open.
    tbl.push_back({1'b1, 1'b0, 2'd0, 1'b0, ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1)});
    tbl.push_back({1'b0, 1'b0, 2'd0, 1'b0, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1)});
    tbl.push_back({1'b0, 1'b0, 2'd3, 1'b1, ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0)});
    for (int k = 0; k < 7; k++)
      tbl.push_back({1'b0, 1'b0, (k == 2) ? 2'd2 : 2'd0, (k == 2),
                     ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0)});
    tbl.push_back({1'b0, 1'b0, 2'd0, 1'b0, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0)});
    // Wrong password -> DENY for 8 clocks; later correct strobe ignored.
    tbl.push_back({1'b1, 1'b0, 2'd0, 1'b0, ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0)});
    tbl.push_back({1'b1, 1'b0, 2'd2, 1'b1, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0)});
    for (int k = 0; k < 7; k++)
      tbl.push_back({1'b0, 1'b0, (k == 0) ? 2'd3 : 2'd0, (k == 0),
                     ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0)});
    tbl.push_back({1'b0, 1'b0, 2'd0, 1'b0, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0)});

    // Reset takes priority over a simultaneous entry request.
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("reset", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].en, tbl[i].ex, tbl[i].pw, tbl[i].pv);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end
    m_occ = 4'd1;

    // Make exit the last-served lane at occupancy 1, then hold both requests.
    enter_car("pre_in");
    exit_car("pre_out");
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    chk("tie_entry_first", ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0));
    step(1'b0, 1'b1, 1'b1, 2'd3, 1'b1);
    chk("tie_open_in", ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0));
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
      chk("tie_hold_in", ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0));
    end
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    chk("tie_back_idle", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0));
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    chk("tie_exit_second", ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0));
    m_occ = 4'd1;
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      chk("tie_hold_out", ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0));
    end
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("tie_done", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0));

    // Fill the lot, entry refused while full, then drain to empty.
    enter_car("fill2");
    enter_car("fill3");
    enter_car("fill4");
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("full_entry_ignored", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0));
    exit_car("drain3");
    exit_car("drain2");
    exit_car("drain1");
    exit_car("drain0");
    step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    chk("empty_exit_ignored", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));

    // Password timeout: 15 clocks waiting, back to IDLE on the 16th.
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("to_grant", ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1));
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      chk($sformatf("to_wait%0d", k), ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1));
    end
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("to_expired", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));

    // Reset in the middle of OPEN_IN.
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("mid_grant", ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1));
    step(1'b0, 1'b0, 1'b0, 2'd3, 1'b1);
    chk("mid_open", ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("mid_hold", ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0));
    step(1'b1, 1'b1, 1'b0, 2'd3, 1'b1);
    chk("mid_reset", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("post_reset_idle", ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
